tlb: RTL

- Fully associative MIPS-style joint TLB with parameterised entry count.
- Provides two registered search ports (s0 instruction fetch, s1 data access), one combinational read port, and one synchronous write port.
- This is the responder end of the interface that the tlb_test stimulus/checker drives.
- Instantiated inside tlb_test for module-level test, then in the CPU core alongside CP0.

---
 rtl/tlb_pkg.sv | 33 +++
 rtl/tlb_search_port.sv | 93 +++++++++
 rtl/tlb.sv | 124 ++++++++++++
 3 files changed

// File: rtl/tlb_pkg.sv
// Shared widths, entry layout and the hit priority helper for the joint TLB.
package tlb_pkg;

    localparam int VPN2_W = 19;
    localparam int ASID_W = 8;
    localparam int PFN_W  = 20;
    localparam int C_W    = 3;

    typedef struct packed {
        logic [VPN2_W-1:0] vpn2;
        logic [ASID_W-1:0] asid;
        logic              g;
        logic [PFN_W-1:0]  pfn0;
        logic [C_W-1:0]    c0;
        logic              d0;
        logic              v0;
        logic [PFN_W-1:0]  pfn1;
        logic [C_W-1:0]    c1;
        logic              d1;
        logic              v1;
    } tlb_entry_t;

    // Multiple hits are a software error; the lowest index wins so the result is deterministic.
    function automatic int lowest_index(input logic [31:0] hits);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (hits[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/tlb_search_port.sv
// One registered TLB search port: match vector, lowest-index select, page-half select, result register.
module tlb_search_port
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 16,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     req,
    input  logic [VPN2_W-1:0]        vpn2,
    input  logic                     odd_page,
    input  logic [ASID_W-1:0]        asid,
    input  tlb_entry_t [TLBNUM-1:0]  entries,
    output logic                     rvalid,
    output logic                     found,
    output logic [IDXW-1:0]          index,
    output logic [PFN_W-1:0]         pfn,
    output logic [C_W-1:0]           c,
    output logic                     d,
    output logic                     v
);

    logic [TLBNUM-1:0] hits;
    logic [31:0]       hits_ext;
    logic              hit_any;
    logic [IDXW-1:0]   hit_idx;
    tlb_entry_t        hit_ent;
    logic [PFN_W-1:0]  sel_pfn;
    logic [C_W-1:0]    sel_c;
    logic              sel_d;
    logic              sel_v;

    always_comb begin
        hits = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            hits[i] = (entries[i].vpn2 == vpn2) && (entries[i].g || (entries[i].asid == asid));
        end
    end

    always_comb begin
        hits_ext = '0;
        hits_ext[TLBNUM-1:0] = hits;
    end

    assign hit_any = |hits;
    assign hit_idx = IDXW'(lowest_index(hits_ext));
    assign hit_ent = entries[hit_idx];

    always_comb begin
        sel_pfn = '0;
        sel_c   = '0;
        sel_d   = 1'b0;
        sel_v   = 1'b0;
        if (hit_any) begin
            if (odd_page) begin
                sel_pfn = hit_ent.pfn1;
                sel_c   = hit_ent.c1;
                sel_d   = hit_ent.d1;
                sel_v   = hit_ent.v1;
            end else begin
                sel_pfn = hit_ent.pfn0;
                sel_c   = hit_ent.c0;
                sel_d   = hit_ent.d0;
                sel_v   = hit_ent.v0;
            end
        end
    end

    // Result fields hold their last value when no request is issued.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rvalid <= 1'b0;
            found  <= 1'b0;
            index  <= '0;
            pfn    <= '0;
            c      <= '0;
            d      <= 1'b0;
            v      <= 1'b0;
        end else begin
            rvalid <= req;
            if (req) begin
                found <= hit_any;
                index <= hit_any ? hit_idx : '0;
                pfn   <= sel_pfn;
                c     <= sel_c;
                d     <= sel_d;
                v     <= sel_v;
            end
        end
    end

endmodule

// File: rtl/tlb.sv
// Fully associative joint TLB: entry storage, synchronous write, combinational read, two search ports.
module tlb
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 16,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              s0_req,
    input  logic [VPN2_W-1:0] s0_vpn2,
    input  logic              s0_odd_page,
    input  logic [ASID_W-1:0] s0_asid,
    output logic              s0_rvalid,
    output logic              s0_found,
    output logic [IDXW-1:0]   s0_index,
    output logic [PFN_W-1:0]  s0_pfn,
    output logic [C_W-1:0]    s0_c,
    output logic              s0_d,
    output logic              s0_v,

    input  logic              s1_req,
    input  logic [VPN2_W-1:0] s1_vpn2,
    input  logic              s1_odd_page,
    input  logic [ASID_W-1:0] s1_asid,
    output logic              s1_rvalid,
    output logic              s1_found,
    output logic [IDXW-1:0]   s1_index,
    output logic [PFN_W-1:0]  s1_pfn,
    output logic [C_W-1:0]    s1_c,
    output logic              s1_d,
    output logic              s1_v,

    input  logic              we,
    input  logic [IDXW-1:0]   w_index,
    input  logic [VPN2_W-1:0] w_vpn2,
    input  logic [ASID_W-1:0] w_asid,
    input  logic              w_g,
    input  logic [PFN_W-1:0]  w_pfn0,
    input  logic [C_W-1:0]    w_c0,
    input  logic              w_d0,
    input  logic              w_v0,
    input  logic [PFN_W-1:0]  w_pfn1,
    input  logic [C_W-1:0]    w_c1,
    input  logic              w_d1,
    input  logic              w_v1,

    input  logic [IDXW-1:0]   r_index,
    output logic [VPN2_W-1:0] r_vpn2,
    output logic [ASID_W-1:0] r_asid,
    output logic              r_g,
    output logic [PFN_W-1:0]  r_pfn0,
    output logic [C_W-1:0]    r_c0,
    output logic              r_d0,
    output logic              r_v0,
    output logic [PFN_W-1:0]  r_pfn1,
    output logic [C_W-1:0]    r_c1,
    output logic              r_d1,
    output logic              r_v1
);

    tlb_entry_t [TLBNUM-1:0] entries;
    tlb_entry_t              r_ent;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            entries <= '0;
        end else if (we) begin
            entries[w_index] <= '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                                  pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                                  pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};
        end
    end

    // Read sees registered storage, so a same-cycle write is not yet visible.
    assign r_ent  = entries[r_index];
    assign r_vpn2 = r_ent.vpn2;
    assign r_asid = r_ent.asid;
    assign r_g    = r_ent.g;
    assign r_pfn0 = r_ent.pfn0;
    assign r_c0   = r_ent.c0;
    assign r_d0   = r_ent.d0;
    assign r_v0   = r_ent.v0;
    assign r_pfn1 = r_ent.pfn1;
    assign r_c1   = r_ent.c1;
    assign r_d1   = r_ent.d1;
    assign r_v1   = r_ent.v1;

    tlb_search_port #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_s0 (
        .clk      (clk),
        .resetn   (resetn),
        .req      (s0_req),
        .vpn2     (s0_vpn2),
        .odd_page (s0_odd_page),
        .asid     (s0_asid),
        .entries  (entries),
        .rvalid   (s0_rvalid),
        .found    (s0_found),
        .index    (s0_index),
        .pfn      (s0_pfn),
        .c        (s0_c),
        .d        (s0_d),
        .v        (s0_v)
    );

    tlb_search_port #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_s1 (
        .clk      (clk),
        .resetn   (resetn),
        .req      (s1_req),
        .vpn2     (s1_vpn2),
        .odd_page (s1_odd_page),
        .asid     (s1_asid),
        .entries  (entries),
        .rvalid   (s1_rvalid),
        .found    (s1_found),
        .index    (s1_index),
        .pfn      (s1_pfn),
        .c        (s1_c),
        .d        (s1_d),
        .v        (s1_v)
    );

endmodule
